// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default vectors for the PC source stage
package pc_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        TRAP     = 2'd1,
        WAIT_ACK = 2'd2,
        HALT     = 2'd3
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_00FF;

endpackage

// File: rtl/pc_source_unit_if.sv
// rtl/pc_source_unit_if.sv - source/control inputs and PC state outputs of the PC source stage
interface pc_source_unit_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 3,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         src_sel;
    logic                     pc_write;
    logic                     pc_write_cond;
    logic                     cond_true;
    logic                     hold;
    logic                     exc_ack;
    logic [WIDTH-1:0]         pc_target;
    logic [WIDTH-1:0]         pc;
    logic [WIDTH-1:0]         pc_prev;
    logic [WIDTH-1:0]         bad_addr;
    logic                     exc_pending;
    logic                     halted;
    logic [CNT_W-1:0]         redirect_cnt;

    modport master (
        output src_data, src_sel, pc_write, pc_write_cond, cond_true, hold, exc_ack,
        input  pc_target, pc, pc_prev, bad_addr, exc_pending, halted, redirect_cnt
    );

    modport slave (
        input  src_data, src_sel, pc_write, pc_write_cond, cond_true, hold, exc_ack,
        output pc_target, pc, pc_prev, bad_addr, exc_pending, halted, redirect_cnt
    );
endinterface

// File: rtl/pc_src_mux.sv
// rtl/pc_src_mux.sv - N-way PC source selector; out-of-range selects fall back to the last source
module pc_src_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 3
) (
    input  logic [NUM_SRC*WIDTH-1:0] i_src_data,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [WIDTH-1:0]         o_target
);
    always_comb begin
        o_target = i_src_data[(NUM_SRC-1)*WIDTH +: WIDTH];
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_target = i_src_data[i*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: rtl/pc_source_unit.sv
// rtl/pc_source_unit.sv - PC register with source select, misaligned-target trap and exception handshake
module pc_source_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               NUM_SRC     = 6,
    parameter int               SEL_W       = 3,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(DEFAULT_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter bit               CHECK_ALIGN = 1'b1,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    pc_source_unit_if.slave  bus
);
    pc_state_t        r_state, w_next;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] r_pc, r_prev, r_bad;
    logic             r_exc;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load, w_mis;
    logic             w_take, w_capture, w_vector, w_clear;

    pc_src_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_mux (
        .i_src_data (bus.src_data),
        .i_sel      (bus.src_sel),
        .o_target   (w_target)
    );

    assign w_load = (bus.pc_write | (bus.pc_write_cond & bus.cond_true)) & ~bus.hold;
    assign w_mis  = CHECK_ALIGN && (w_target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:      if (w_load && w_mis) w_next = TRAP;
            TRAP:     if (!bus.hold) w_next = WAIT_ACK;
            WAIT_ACK: begin
                if (w_load && w_mis)              w_next = HALT;
                else if (bus.exc_ack && !bus.hold) w_next = RUN;
            end
            default:  w_next = HALT;
        endcase
    end

    // A misaligned load in WAIT_ACK wins over a same-cycle acknowledge.
    always_comb begin
        w_take    = 1'b0;
        w_capture = 1'b0;
        w_vector  = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            RUN: begin
                w_take    = w_load & ~w_mis;
                w_capture = w_load & w_mis;
            end
            TRAP:     w_vector = ~bus.hold;
            WAIT_ACK: begin
                w_take    = w_load & ~w_mis;
                w_capture = w_load & w_mis;
                w_clear   = bus.exc_ack & ~bus.hold & ~(w_load & w_mis);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc   <= RESET_PC;
            r_prev <= RESET_PC;
            r_bad  <= '0;
            r_exc  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_take) begin
                r_pc   <= w_target;
                r_prev <= r_pc;
            end else if (w_vector) begin
                r_pc   <= EXC_VECTOR;
                r_prev <= r_pc;
            end
            if (w_capture) r_bad <= w_target;
            if (w_vector)     r_exc <= 1'b1;
            else if (w_clear) r_exc <= 1'b0;
            if ((w_take || w_vector) && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.pc_target    = w_target;
    assign bus.pc           = r_pc;
    assign bus.pc_prev      = r_prev;
    assign bus.bad_addr     = r_bad;
    assign bus.exc_pending  = r_exc;
    assign bus.halted       = (r_state == HALT);
    assign bus.redirect_cnt = r_cnt;
endmodule
